// File: rtl/inst_sequencer.sv
// Multi-cycle fetch/execute/write-back sequencer for the RV32 core, with a coprocessor handshake.
// Optional SEQ_CP_TIMEOUT_EN halts on a coprocessor that never answers within CP_TIMEOUT cycles.
module inst_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned CP_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run_en,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  input  logic        dec_w_en,
  output logic        rf_we,
  output logic        cp_start,
  input  logic        cp_done,
  output logic        retire,
  output logic        halted,
  output logic [1:0]  halt_cause
);

  localparam logic [2:0] S_FETCH   = 3'd0;
  localparam logic [2:0] S_EXEC    = 3'd1;
  localparam logic [2:0] S_CP_WAIT = 3'd2;
  localparam logic [2:0] S_WB      = 3'd3;
  localparam logic [2:0] S_HALT    = 3'd4;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_CUST0 = 7'b0001011;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_CP_TMO  = 2'b10;

  logic [2:0]  state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] inst_n;
  logic        imem_req_n, rf_we_n, cp_start_n, retire_n, halted_n;
  logic [1:0]  halt_cause_n;

`ifdef SEQ_CP_TIMEOUT_EN
  localparam int unsigned CNT_W = (CP_TIMEOUT > 1) ? $clog2(CP_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CP_LAST = CNT_W'(CP_TIMEOUT - 1);
  logic [CNT_W-1:0] cp_cnt, cp_cnt_n;
`else
  logic unused_cp_timeout;
  assign unused_cp_timeout = ^32'(CP_TIMEOUT);
`endif

  // Terminal-count decision is unused when the watchdog is not built.
  logic cp_expired;
`ifdef SEQ_CP_TIMEOUT_EN
  assign cp_expired = (cp_cnt == CP_LAST);
`else
  assign cp_expired = 1'b0;
`endif

  assign imem_addr = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_FETCH;
      pc         <= RESET_PC;
      inst       <= 32'h0000_0000;
      imem_req   <= 1'b0;
      rf_we      <= 1'b0;
      cp_start   <= 1'b0;
      retire     <= 1'b0;
      halted     <= 1'b0;
      halt_cause <= 2'b00;
    end else begin
      state      <= state_n;
      pc         <= pc_n;
      inst       <= inst_n;
      imem_req   <= imem_req_n;
      rf_we      <= rf_we_n;
      cp_start   <= cp_start_n;
      retire     <= retire_n;
      halted     <= halted_n;
      halt_cause <= halt_cause_n;
    end
  end

`ifdef SEQ_CP_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cp_cnt <= '0;
    else        cp_cnt <= cp_cnt_n;
  end
`endif

  // Next state plus next values of every registered strobe; strobes default low.
  always_comb begin
    state_n      = state;
    pc_n         = pc;
    inst_n       = inst;
    imem_req_n   = 1'b0;
    rf_we_n      = 1'b0;
    cp_start_n   = 1'b0;
    retire_n     = 1'b0;
    halt_cause_n = halt_cause;
`ifdef SEQ_CP_TIMEOUT_EN
    cp_cnt_n     = cp_cnt;
`endif
    unique case (state)
      S_FETCH: begin
        if (imem_req && imem_ack) begin
          inst_n  = imem_rdata;
          state_n = S_EXEC;
        end else begin
          // An outstanding request is never withdrawn, even if run_en falls.
          imem_req_n = imem_req | run_en;
        end
      end
      S_EXEC: begin
        if (inst[6:0] == OP_R || inst[6:0] == OP_I) begin
          state_n  = S_WB;
          rf_we_n  = dec_w_en;
          retire_n = 1'b1;
        end else if (inst[6:0] == OP_CUST0) begin
          state_n    = S_CP_WAIT;
          cp_start_n = 1'b1;
`ifdef SEQ_CP_TIMEOUT_EN
          cp_cnt_n   = '0;
`endif
        end else begin
          state_n      = S_HALT;
          halt_cause_n = CAUSE_ILLEGAL;
        end
      end
      S_CP_WAIT: begin
        if (cp_done) begin
          state_n  = S_WB;
          rf_we_n  = dec_w_en;
          retire_n = 1'b1;
        end else if (cp_expired) begin
          state_n      = S_HALT;
          halt_cause_n = CAUSE_CP_TMO;
        end else begin
`ifdef SEQ_CP_TIMEOUT_EN
          cp_cnt_n = cp_cnt + CNT_W'(1);
`endif
        end
      end
      S_WB: begin
        pc_n       = pc + 32'd4;
        state_n    = S_FETCH;
        imem_req_n = run_en;
      end
      S_HALT: begin
        state_n = S_HALT;
      end
      default: begin
        state_n = S_FETCH;
      end
    endcase
    halted_n = (state_n == S_HALT);
  end

endmodule
